// File: rtl/jk_seq_arbiter.sv
// Two-requester round-robin arbiter that sequences j/k commands into an
// external jk_ff for a programmable number of clock edges, then reports q.
module jk_seq_arbiter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [CNT_W-1:0] req0_cnt,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [CNT_W-1:0] req1_cnt,
  output logic             req1_ready,
  output logic             j,
  output logic             k,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             done_q
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             id_q, id_d;
  logic             last_id_q, last_id_d;
  logic             j_q, j_d;
  logic             k_q, k_d;

  logic             gnt0, gnt1, xfer;
  logic [1:0]       sel_op;
  logic [CNT_W-1:0] sel_cnt;

  // Contention goes to whichever requester was not served last.
  assign gnt0 = req0_valid && (!req1_valid || last_id_q);
  assign gnt1 = req1_valid && (!req0_valid || !last_id_q);

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;
  assign xfer       = req0_ready || req1_ready;
  assign sel_op     = gnt1 ? req1_op  : req0_op;
  assign sel_cnt    = gnt1 ? req1_cnt : req0_cnt;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    j_d       = j_q;
    k_d       = k_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          id_d      = gnt1;
          last_id_d = gnt1;
          if (sel_cnt != '0) begin
            state_d = DRIVE;
            rem_d   = sel_cnt;
            // op encoding maps directly onto {j,k}: hold/reset/set/toggle.
            j_d     = sel_op[1];
            k_d     = sel_op[0];
          end else begin
            state_d = SETTLE;
          end
        end
      end
      DRIVE: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = SETTLE;
          j_d     = 1'b0;
          k_d     = 1'b0;
        end
      end
      SETTLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        j_d     = 1'b0;
        k_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      j_q       <= j_d;
      k_q       <= k_d;
    end
  end

  assign j       = j_q;
  assign k       = k_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == SETTLE);
  assign done_id = done && id_q;
  assign done_q  = done && q;

endmodule

// File: tb/tb_jk_seq_arbiter.sv
// Directed cycle-by-cycle bench for jk_seq_arbiter driving a behavioural jk_ff.
module tb_jk_seq_arbiter;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]       req0_op = '0, req1_op = '0;
  logic [CNT_W-1:0] req0_cnt = '0, req1_cnt = '0;
  logic             req0_ready, req1_ready;
  logic             j, k, busy, done, done_id, done_q;
  logic             q = 1'b0;

  int total = 0;
  int bad   = 0;

  jk_seq_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_cnt(req0_cnt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_cnt(req1_cnt), .req1_ready(req1_ready),
    .j(j), .k(k), .q(q),
    .busy(busy), .done(done), .done_id(done_id), .done_q(done_q)
  );

  always #5 clk = ~clk;

  // External flip-flop: no reset, so reset of the sequencer leaves q alone.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end

  typedef struct {
    logic             rst;
    logic             v0;
    logic [1:0]       op0;
    logic [CNT_W-1:0] c0;
    logic             v1;
    logic [1:0]       op1;
    logic [CNT_W-1:0] c1;
    logic [7:0]       exp;  // {r0,r1,j,k,busy,done,done_id,done_q}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic v0, logic [1:0] op0, int c0,
                              logic v1, logic [1:0] op1, int c1, logic [7:0] exp);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.op0 = op0; v.c0 = CNT_W'(c0);
    v.v1 = v1; v.op1 = op1; v.c1 = CNT_W'(c1); v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {req0_ready, req1_ready, j, k, busy, done, done_id, done_q};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // initialise: reset op, cnt=1 from req0
    vecs.push_back(mk(1, 1, 2'b01, 1, 0, 0, 0, 8'b1000_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0001_1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0000_1100));
    // toggle run: req1 toggle x3 from q=0
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'b11, 3, 8'b0100_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0011_1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0011_1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0011_1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0000_1111));
    // reset, then contention: req0 wins first tie
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b0000_0000));
    vecs.push_back(mk(1, 1, 2'b10, 1, 1, 2'b01, 2, 8'b1000_0000));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'b01, 2, 8'b0010_1000));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'b01, 2, 8'b0000_1101));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'b01, 2, 8'b0100_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0001_1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0001_1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0000_1110));
    // both valid again after req1 served: req0 granted; then req1 cnt=0
    vecs.push_back(mk(1, 1, 2'b10, 1, 1, 2'b11, 0, 8'b1000_0000));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'b11, 0, 8'b0010_1000));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'b11, 0, 8'b0000_1101));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'b11, 0, 8'b0100_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0000_1111));
    // zero count: reset op with cnt=0 leaves q=1
    vecs.push_back(mk(1, 1, 2'b01, 0, 0, 0, 0, 8'b1000_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0000_1101));
    // back-to-back: req0 holds two set cnt=2 commands
    vecs.push_back(mk(1, 1, 2'b10, 2, 0, 0, 0, 8'b1000_0000));
    vecs.push_back(mk(1, 1, 2'b10, 2, 0, 0, 0, 8'b0010_1000));
    vecs.push_back(mk(1, 1, 2'b10, 2, 0, 0, 0, 8'b0010_1000));
    vecs.push_back(mk(1, 1, 2'b10, 2, 0, 0, 0, 8'b0000_1101));
    vecs.push_back(mk(1, 1, 2'b10, 2, 0, 0, 0, 8'b1000_0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0010_1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0010_1000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0000_1101));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'b0000_0000));

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 8'b0000_0000);
    check1("reset_q", q, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      rst_n      = vecs[i].rst;
      req0_valid = vecs[i].v0; req0_op = vecs[i].op0; req0_cnt = vecs[i].c0;
      req1_valid = vecs[i].v1; req1_op = vecs[i].op1; req1_cnt = vecs[i].c1;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // reset mid-run: req0 toggle cnt=15, reset during the 5th DRIVE cycle
    req0_valid = 1'b1; req0_op = 2'b11; req0_cnt = 4'd15;
    @(negedge clk);
    check("midrst_accept", outs(), 8'b1000_0000);
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_op = '0; req0_cnt = '0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("midrst_drive5", outs(), 8'b0011_1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async", outs(), 8'b0000_0000);
    @(negedge clk);
    check1("midrst_q_kept", q, 1'b1);
    @(posedge clk); #1;
    check1("midrst_q_held", q, 1'b1);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_cnt = '0;
    @(negedge clk);
    check("midrst_first_idle", outs(), 8'b1000_0000);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("midrst_done_after", outs(), 8'b0000_1101);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_seq_arbiter.md
# jk_seq_arbiter

Command sequencer and two-requester round-robin arbiter for a shared external `jk_ff`. Each requester submits an operation (hold / reset / set / toggle) and a repeat count through a valid/ready handshake. The block drives the flip-flop's `j`/`k` inputs for that many clock edges, then reports the resulting `q` with a one-cycle `done` pulse. It sits between control logic and a single `jk_ff` instance clocked by the same `clk`.

## Interface
- `CNT_W`, default 4: width of the repeat-count field. Maximum count is 2^CNT_W-1.

- `clk`  in  1  system clock, rising-edge; the external `jk_ff` shares it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has a command.
- `req0_op`  in  2  requester 0 operation: 00 hold, 01 reset, 10 set, 11 toggle.
- `req0_cnt`  in  CNT_W  requester 0 count of active clock edges.
- `req0_ready`  out  1  requester 0 command accepted this cycle when `req0_valid` is also high.
- `req1_valid`, `req1_op`, `req1_cnt`, `req1_ready`: same widths and meanings, requester 1.
- `j`  out  1  to `jk_ff.j`; registered.
- `k`  out  1  to `jk_ff.k`; registered.
- `q`  in  1  from `jk_ff.q`.
- `busy`  out  1  a command is in progress (state is not IDLE).
- `done`  out  1  one-cycle pulse when a command completes.
- `done_id`  out  1  requester that issued the completed command; valid while `done`=1.
- `done_q`  out  1  `q` sampled after the last active edge; valid while `done`=1.

## Operation
- States: IDLE, DRIVE, SETTLE.
- IDLE:
  - j=k=0, busy=0.
  - Grant logic is combinational from both valids and the `last_id` register:
    - only one requester valid → that requester is granted;
    - both valid → the requester other than `last_id` is granted.
  - `reqN_ready` = (state==IDLE) && (grant==N). At most one ready is high in any cycle.
  - A transfer occurs on a rising edge with valid&&ready. At that edge the block latches op, cnt and id, and sets `last_id` to id.
  - After a transfer: cnt≥1 → DRIVE, with `remaining`=cnt. cnt=0 → SETTLE.
- DRIVE:
  - j/k are taken from the latched op: hold 0/0, reset 0/1, set 1/0, toggle 1/1.
  - `remaining` decrements on every edge.
  - On the edge where `remaining`==1, move to SETTLE with j=k=0.
  - DRIVE therefore lasts exactly cnt cycles, giving exactly cnt active edges into the flip-flop.
- SETTLE:
  - j=k=0.
  - done=1; done_id = latched id; done_q = `q` (combinational pass-through of `q`, which reflects the last active edge).
  - Next edge → IDLE.
- `valid`, `op` and `cnt` from a requester that is not granted are ignored. Requesters must hold their command stable until ready.
- `op` is irrelevant when cnt=0: no edge is applied and q is unchanged.
- `reqN_*` inputs are not sampled outside IDLE.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; j=0, k=0, busy=0, done=0, done_id=0, done_q=0;
  - `last_id`=1, so requester 0 wins the first tie;
  - `remaining`=0.
- Reset asserted mid-command: the command is discarded. j/k go to 0 in the same instant, no done pulse is issued, and q keeps whatever edges already occurred.
- Latency for cnt≥1:
  - accept edge E0;
  - j/k active during cycles E0..E0+cnt-1;
  - done high in the cycle after E0+cnt;
  - IDLE at E0+cnt+1, and a new accept is possible on that cycle's closing edge.
- Throughput: one command per cnt+2 cycles for cnt≥1, and one per 2 cycles for cnt=0.
- `busy` is high from the cycle after accept through the SETTLE cycle inclusive.
- j/k never change except on a `clk` edge or on reset assertion.

## Test plan
- **Initialise:** after reset release, req0 op=01 cnt=1 → req0_ready=1 in that cycle; j=0,k=1 for 1 cycle; next cycle done=1, done_id=0, done_q=0.
- **Toggle run:** from q=0, req1 op=11 cnt=3 → j=k=1 for exactly 3 cycles, then done=1, done_id=1, done_q=1; busy high for 4 cycles.
- **Contention:**
  - right after reset, req0 (op=10 cnt=1) and req1 (op=01 cnt=2) are both valid → req0 first (done_q=1), then req1 (done_q=0);
  - both valid again → req0 granted.
- **Zero count:** with q=1, req0 op=01 cnt=0 → no j/k activity; done on the cycle after accept with done_q=1.
- **Reset mid-run:** req0 op=11 cnt=15, rst_n asserted during the 5th DRIVE cycle → j=k=0, busy=0, done=0 immediately; after release, req0_ready=1 on the first IDLE cycle.
- **Back-to-back:** req0 holds valid for two op=10 cnt=2 commands → accepts are 4 cycles apart; two done pulses, each with done_id=0.
